conv1_mac_acc: RTL

// - Conv1 MAC engine, directly downstream of the conv1 kernel/weight streamer.
// - Each cycle it multiplies one streamed pixel by the 3 streamed channel weights.
// - Accumulates 25 taps (5x5) per channel, adds the channel bias, then shifts and saturates.
// - Emits 3 signed 16-bit conv1 results per window, each with a 1-cycle out_valid pulse.

---
 rtl/conv1_mac_acc_if.sv | 21 ++
 rtl/conv1_mac_acc.sv | 125 ++++++++++++
 2 files changed

// File: rtl/conv1_mac_acc_if.sv
// Conv1 MAC engine bus: streamer-side inputs (start, pixel, weights, bias) and
// the per-window results. The master drives the stream; the slave is the MAC.
interface conv1_mac_acc_if;
  logic                   start;
  logic signed [15:0]     pixel_in;
  logic        [3:1][15:0] weight_conv1;
  logic        [3:1][15:0] bias_conv1;
  logic        [3:1][15:0] conv_out;
  logic                   out_valid;
  logic        [15:0]     win_count;

  modport master (
    output start, pixel_in, weight_conv1, bias_conv1,
    input  conv_out, out_valid, win_count
  );

  modport slave (
    input  start, pixel_in, weight_conv1, bias_conv1,
    output conv_out, out_valid, win_count
  );
endinterface

// File: rtl/conv1_mac_acc.sv
// Conv1 MAC: 25-tap x 3-channel Q8.8 multiply-accumulate, bias, shift, saturate.
// Optional macro CONV1_RELU_EN clamps negative saturated results to zero.
module conv1_mac_acc #(
  parameter int unsigned TAPS        = 25,
  parameter int unsigned FILL_CYCLES = 2,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned ACC_W       = 40
) (
  input  logic             clk,
  input  logic             n_reset,
  conv1_mac_acc_if.slave   bus
);

  localparam int unsigned TAP_W  = $clog2(TAPS + 1);
  localparam int unsigned FILL_W = $clog2(FILL_CYCLES + 1);
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ACCUM} state_t;

  state_t                   r_state, w_state_nxt;
  logic [TAP_W-1:0]         r_tap;
  logic [FILL_W-1:0]        r_fill;
  logic signed [ACC_W-1:0]  r_acc [3:1];
  logic [3:1][15:0]         r_conv;
  logic                     r_valid;
  logic [15:0]              r_win;

  logic signed [31:0]       w_prod     [3:1];
  logic signed [ACC_W-1:0]  w_acc_nxt  [3:1];
  logic signed [SUM_W-1:0]  w_sum      [3:1];
  logic signed [SUM_W-1:0]  w_res      [3:1];
  logic [3:1][15:0]         w_sat;
  logic                     w_last;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    if (!bus.start) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_nxt = S_FILL;
        S_FILL:  if (r_fill == FILL_W'(FILL_CYCLES - 1)) w_state_nxt = S_ACCUM;
        S_ACCUM: w_last = (r_tap == TAP_W'(TAPS));
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Every term is explicitly sign-extended to SUM_W so the final tap cannot wrap
  // before the shift/saturate stage.
  always_comb begin
    w_sat = '0;
    for (int unsigned c = 1; c <= 3; c++) begin
      w_prod[c]    = $signed(bus.pixel_in) * $signed(bus.weight_conv1[c]);
      w_acc_nxt[c] = r_acc[c] + {{(ACC_W-32){w_prod[c][31]}}, w_prod[c]};
      w_sum[c]     = {r_acc[c][ACC_W-1], r_acc[c]}
                   + {{(SUM_W-32){w_prod[c][31]}}, w_prod[c]}
                   + {{(SUM_W-16-FRAC_BITS){bus.bias_conv1[c][15]}},
                      bus.bias_conv1[c], {FRAC_BITS{1'b0}}};
      w_res[c]     = w_sum[c] >>> FRAC_BITS;
      if ((&w_res[c][SUM_W-1:15]) || !(|w_res[c][SUM_W-1:15]))
        w_sat[c] = w_res[c][15:0];
      else if (w_res[c][SUM_W-1])
        w_sat[c] = 16'h8000;
      else
        w_sat[c] = 16'h7FFF;
`ifdef CONV1_RELU_EN
      if (w_sat[c][15]) w_sat[c] = '0;
`else
      w_sat[c] = w_sat[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_tap   <= '0;
      r_fill  <= '0;
      r_conv  <= '0;
      r_valid <= 1'b0;
      r_win   <= '0;
      for (int unsigned c = 1; c <= 3; c++) r_acc[c] <= '0;
    end else if (!bus.start) begin
      r_tap   <= '0;
      r_fill  <= '0;
      r_conv  <= '0;
      r_valid <= 1'b0;
      r_win   <= '0;
      for (int unsigned c = 1; c <= 3; c++) r_acc[c] <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: r_fill <= FILL_W'(1);
        S_FILL: begin
          r_fill <= r_fill + FILL_W'(1);
          if (w_state_nxt == S_ACCUM) r_tap <= TAP_W'(1);
        end
        S_ACCUM: begin
          if (w_last) begin
            r_conv  <= w_sat;
            r_valid <= 1'b1;
            r_win   <= r_win + 16'd1;
            r_tap   <= TAP_W'(1);
            for (int unsigned c = 1; c <= 3; c++) r_acc[c] <= '0;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
            for (int unsigned c = 1; c <= 3; c++) r_acc[c] <= w_acc_nxt[c];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.conv_out  = r_conv;
  assign bus.out_valid = r_valid;
  assign bus.win_count = r_win;

endmodule
